// File: rtl/fetch_pkg.sv
// Shared types and default widths for the instruction-fetch front end.
package fetch_pkg;

    localparam int                    FETCH_XLEN     = 16;
    localparam int                    FETCH_ILEN     = 16;
    localparam logic [FETCH_XLEN-1:0] FETCH_RESET_PC = 16'h0000;

    typedef enum logic [1:0] {RUN, DRAIN, ERR} fetch_state_t;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_ILEN-1:0] data;
        logic                  filled;
    } fetch_slot_t;

endpackage

// File: rtl/fetch_slot_buf.sv
// Circular slot buffer: slots are allocated at request time, filled in order
// by responses and retired from the head once filled.
module fetch_slot_buf #(
    parameter int XLEN   = 16,
    parameter int ILEN   = 16,
    parameter int QDEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     alloc,
    input  logic [XLEN-1:0]          alloc_pc,
    input  logic                     fill,
    input  logic [ILEN-1:0]          fill_data,
    input  logic                     retire,
    output logic                     head_filled,
    output logic [XLEN-1:0]          head_pc,
    output logic [ILEN-1:0]          head_data,
    output logic [$clog2(QDEPTH):0]  count,
    output logic [$clog2(QDEPTH):0]  pending
);
    localparam int AW = $clog2(QDEPTH);

    // Same layout as fetch_pkg::fetch_slot_t, sized by this instance's widths.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] data;
        logic            filled;
    } slot_t;

    slot_t         slots [QDEPTH];
    logic [AW:0]   alloc_ptr, fill_ptr, ret_ptr;
    logic          do_alloc, do_fill, do_retire;

    assign count       = alloc_ptr - ret_ptr;
    assign pending     = alloc_ptr - fill_ptr;
    assign head_filled = slots[ret_ptr[AW-1:0]].filled;
    assign head_pc     = slots[ret_ptr[AW-1:0]].pc;
    assign head_data   = slots[ret_ptr[AW-1:0]].data;

    // Guards keep the pointers consistent even if a caller misbehaves.
    assign do_alloc  = alloc && (count != (AW+1)'(QDEPTH));
    assign do_fill   = fill && (pending != '0);
    assign do_retire = retire && head_filled;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < QDEPTH; i++) slots[i] <= '0;
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            ret_ptr   <= '0;
        end else if (flush) begin
            for (int i = 0; i < QDEPTH; i++) slots[i].filled <= 1'b0;
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            ret_ptr   <= '0;
        end else begin
            if (do_alloc) begin
                slots[alloc_ptr[AW-1:0]] <= '{pc: alloc_pc, data: '0, filled: 1'b0};
                alloc_ptr <= alloc_ptr + (AW+1)'(1);
            end
            if (do_fill) begin
                slots[fill_ptr[AW-1:0]].data   <= fill_data;
                slots[fill_ptr[AW-1:0]].filled <= 1'b1;
                fill_ptr <= fill_ptr + (AW+1)'(1);
            end
            if (do_retire) begin
                slots[ret_ptr[AW-1:0]].filled <= 1'b0;
                ret_ptr <= ret_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: in-order imem requests, slot buffering, IF/ID
// handshake, redirect squash with response draining, and a sticky error.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int              XLEN     = FETCH_XLEN,
    parameter int              ILEN     = FETCH_ILEN,
    parameter int              QDEPTH   = 4,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(FETCH_RESET_PC)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_pc,
    input  logic             halt,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [XLEN-1:0]  imem_req_addr,
    input  logic             imem_rsp_valid,
    input  logic [ILEN-1:0]  imem_rsp_data,
    input  logic             imem_rsp_err,
    output logic             inst_valid,
    input  logic             inst_ready,
    output logic [ILEN-1:0]  inst_ifid,
    output logic [XLEN-1:0]  pc_ifid,
    output logic             err
);
    localparam int              CW     = $clog2(QDEPTH) + 1;
    localparam logic [XLEN-1:0] PC_INC = XLEN'(ILEN / 8);

    fetch_state_t    state, state_n;
    logic [XLEN-1:0] pc, pc_n;
    logic [CW-1:0]   drop_cnt, drop_n, count, pending, owed;
    logic [CW:0]     inflight;
    logic            head_filled, req_fire, fill, retire, misaligned;

    // Buffered slots plus responses still owed to earlier redirects share QDEPTH.
    assign inflight       = {1'b0, count} + {1'b0, drop_cnt};
    assign imem_req_valid = rst && (state == RUN) && !halt && !redirect_valid
                            && (inflight < (CW+1)'(QDEPTH));
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // drop_cnt is always zero in RUN, so any RUN response belongs to a live slot.
    assign fill       = imem_rsp_valid && !redirect_valid && (state == RUN) && !imem_rsp_err;
    assign inst_valid = head_filled && !redirect_valid;
    assign retire     = inst_valid && inst_ready;
    assign err        = (state == ERR);
    assign misaligned = (redirect_pc % PC_INC) != '0;
    assign owed       = drop_cnt + pending;

    fetch_slot_buf #(.XLEN(XLEN), .ILEN(ILEN), .QDEPTH(QDEPTH)) u_slots (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect_valid),
        .alloc      (req_fire),
        .alloc_pc   (pc),
        .fill       (fill),
        .fill_data  (imem_rsp_data),
        .retire     (retire),
        .head_filled(head_filled),
        .head_pc    (pc_ifid),
        .head_data  (inst_ifid),
        .count      (count),
        .pending    (pending)
    );

    always_comb begin
        state_n = state;
        pc_n    = pc;
        drop_n  = drop_cnt;
        if (redirect_valid) begin
            pc_n = redirect_pc;
            if (state != ERR) begin
                // A response landing in the redirect cycle is one of those owed.
                drop_n  = owed - CW'(imem_rsp_valid && (owed != '0));
                state_n = (drop_n != '0) ? DRAIN : RUN;
            end
            if (misaligned) state_n = ERR;
        end else begin
            case (state)
                RUN: begin
                    if (req_fire) pc_n = pc + PC_INC;
                    if (imem_rsp_valid && imem_rsp_err) state_n = ERR;
                end
                DRAIN: begin
                    if (imem_rsp_valid) begin
                        drop_n = drop_cnt - CW'(1);
                        if (drop_cnt == CW'(1)) state_n = RUN;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= RUN;
            pc       <= RESET_PC;
            drop_cnt <= '0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            drop_cnt <= drop_n;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus random traffic, checked against
// a stream/epoch model of which instructions decode must see.
module tb_fetch_queue;
    localparam int XLEN = 16, ILEN = 16, QDEPTH = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             redirect_valid = 1'b0;
    logic [XLEN-1:0]  redirect_pc = '0;
    logic             halt = 1'b0;
    logic             imem_req_valid;
    logic             imem_req_ready = 1'b0;
    logic [XLEN-1:0]  imem_req_addr;
    logic             imem_rsp_valid = 1'b0;
    logic [ILEN-1:0]  imem_rsp_data = '0;
    logic             imem_rsp_err = 1'b0;
    logic             inst_valid;
    logic             inst_ready = 1'b0;
    logic [ILEN-1:0]  inst_ifid;
    logic [XLEN-1:0]  pc_ifid;
    logic             err;

    always #5 clk = ~clk;

    fetch_queue #(.XLEN(XLEN), .ILEN(ILEN), .QDEPTH(QDEPTH), .RESET_PC(16'h0000)) dut (
        .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .halt(halt), .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .imem_rsp_err(imem_rsp_err),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_ifid(inst_ifid),
        .pc_ifid(pc_ifid), .err(err)
    );

    // Memory request log: address plus the redirect epoch it was issued in.
    typedef struct { logic [15:0] addr; int tag; } req_t;
    req_t mq[$];

    int tests = 0, fails = 0;
    int epoch, rsp_num, err_at = -1, rsp_pct = 100, cyc, nfire, ndec, tot_dec = 0;
    int first_fire, first_valid, cur_tag, snap;
    logic mem_en = 1'b1, exp_err, fault_valid;
    logic [15:0] exp_req_pc, exp_dec_pc, fault_pc, cur_addr;

    function automatic logic [15:0] memfn(input logic [15:0] a);
        return (a * 16'h9E37) ^ 16'h5A5A;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_rsp();
        imem_rsp_valid = 1'b0;
        imem_rsp_err   = 1'b0;
        imem_rsp_data  = '0;
        if (mem_en && mq.size() > 0 && int'($urandom_range(99)) < rsp_pct) begin
            cur_addr = mq[0].addr;
            cur_tag  = mq[0].tag;
            void'(mq.pop_front());
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memfn(cur_addr);
            imem_rsp_err   = (rsp_num == err_at);
            rsp_num++;
        end
    endtask

    task automatic tick();
        logic fire, dec, stale;
        @(negedge clk);
        fire = imem_req_valid && imem_req_ready;
        dec  = inst_valid && inst_ready;
        check("err_flag", 32'(err), 32'(exp_err));
        check("outstanding_bound", 32'(mq.size() <= QDEPTH), 32'd1);
        if (exp_err) check("no_req_in_err", 32'(imem_req_valid), 32'd0);
        if (redirect_valid) check("inst_void_on_redirect", 32'(inst_valid), 32'd0);
        if (fire) begin
            if (first_fire < 0) first_fire = cyc;
            nfire++;
            check("req_addr", 32'(imem_req_addr), 32'(exp_req_pc));
            mq.push_back('{imem_req_addr, epoch});
            exp_req_pc = exp_req_pc + 16'(ILEN / 8);
        end
        if (inst_valid && first_valid < 0) first_valid = cyc;
        if (dec) begin
            ndec++;
            tot_dec++;
            check("dec_pc", 32'(pc_ifid), 32'(exp_dec_pc));
            check("dec_data", 32'(inst_ifid), 32'(memfn(exp_dec_pc)));
            if (fault_valid) check("fault_slot_hidden", 32'(pc_ifid != fault_pc), 32'd1);
            exp_dec_pc = exp_dec_pc + 16'(ILEN / 8);
        end
        if (imem_rsp_valid) begin
            stale = (cur_tag != epoch) || redirect_valid;
            if (!stale && imem_rsp_err && !exp_err) begin
                exp_err     = 1'b1;
                fault_valid = 1'b1;
                fault_pc    = cur_addr;
            end
        end
        if (redirect_valid) begin
            epoch++;
            exp_req_pc = redirect_pc;
            exp_dec_pc = redirect_pc;
            if (redirect_pc[0]) exp_err = 1'b1;
        end
        cyc++;
        @(posedge clk);
        #1;
        drive_rsp();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        redirect_valid = 1'b0;
        halt = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_err = 1'b0;
        #1;
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_inst_valid", 32'(inst_valid), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_inst_ifid", 32'(inst_ifid), 32'd0);
        check("rst_pc_ifid", 32'(pc_ifid), 32'd0);
        mq.delete();
        epoch = 0; rsp_num = 0; cyc = 0; nfire = 0; ndec = 0;
        first_fire = -1; first_valid = -1;
        exp_req_pc = 16'h0000; exp_dec_pc = 16'h0000;
        exp_err = 1'b0; fault_valid = 1'b0; fault_pc = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive_rsp();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: streaming fetch with single-cycle memory
        imem_req_ready = 1'b1; inst_ready = 1'b1; mem_en = 1'b1; rsp_pct = 100;
        do_reset();
        repeat (12) tick();
        check("t1_first_fire_cycle", 32'(first_fire), 32'd0);
        check("t1_req_to_valid", 32'(first_valid - first_fire), 32'd2);
        check("t1_throughput", 32'(ndec), 32'd10);

        // 2: decode stalled, buffer fills to QDEPTH then drains in order
        do_reset();
        inst_ready = 1'b0;
        repeat (10) tick();
        check("t2_fires_when_full", 32'(nfire), 32'(QDEPTH));
        #1;
        check("t2_req_held", 32'(imem_req_valid), 32'd0);
        inst_ready = 1'b1;
        repeat (12) tick();
        check("t2_drained", 32'(ndec >= QDEPTH), 32'd1);
        check("t2_issue_resumed", 32'(nfire > QDEPTH), 32'd1);

        // 3: redirect with three requests outstanding
        do_reset();
        mem_en = 1'b0;
        repeat (3) tick();
        check("t3_outstanding", 32'(nfire), 32'd3);
        redirect_valid = 1'b1; redirect_pc = 16'h0040;
        tick();
        redirect_valid = 1'b0;
        mem_en = 1'b1;
        for (int i = 0; i < 30 && ndec < 3; i++) tick();
        check("t3_target_decoded", 32'(ndec >= 3), 32'd1);

        // 4: redirect colliding with a decode handshake and a response
        do_reset();
        repeat (5) tick();
        snap = ndec;
        redirect_valid = 1'b1; redirect_pc = 16'h0080;
        tick();
        redirect_valid = 1'b0;
        check("t4_handshake_void", 32'(ndec), 32'(snap));
        for (int i = 0; i < 20 && ndec < snap + 3; i++) tick();
        check("t4_recovered", 32'(ndec >= snap + 3), 32'd1);

        // 5: bus error on the 2nd response
        err_at = 1;
        do_reset();
        repeat (10) tick();
        check("t5_one_delivered", 32'(ndec), 32'd1);
        check("t5_no_more_reqs", 32'(nfire), 32'd3);
        check("t5_err_sticky", 32'(err), 32'd1);
        err_at = -1;

        // 6: misaligned redirect target
        do_reset();
        repeat (2) tick();
        redirect_valid = 1'b1; redirect_pc = 16'h0003;
        tick();
        redirect_valid = 1'b0;
        repeat (8) tick();
        check("t6_err", 32'(err), 32'd1);
        check("t6_no_req", 32'(nfire), 32'd2);

        // Random traffic, including a reset mid-stream and PC wrap targets
        do_reset();
        rsp_pct = 60;
        tot_dec = 0;
        for (int i = 0; i < 1500; i++) begin
            imem_req_ready = ($urandom_range(3) != 0);
            inst_ready     = ($urandom_range(3) != 0);
            halt           = ($urandom_range(9) == 0);
            redirect_valid = ($urandom_range(29) == 0);
            redirect_pc    = ($urandom_range(3) == 0) ? 16'hFFF8 : (16'($urandom) & 16'hFFFE);
            tick();
            if (i == 800) do_reset();
        end
        redirect_valid = 1'b0;
        check("rand_progress", 32'(tot_dec > 100), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
Parametrised instruction-fetch front end for the uRISC pipeline. It replaces the single-instruction fetch stage.
- Issues in-order requests to instruction memory over a valid/ready handshake, with up to QDEPTH in flight or buffered.
- Presents instructions and their PCs to decode over a valid/ready IF/ID handshake.
- Supports branch redirect with squash of in-flight responses, and reports a sticky error.

Parameters:
XLEN, 16, PC/address width in bits.
ILEN, 16, instruction width in bits. Must be a multiple of 8. PC increment is ILEN/8.
QDEPTH, 4, slot-buffer depth. Power of two, at least 2. It is also the maximum number of outstanding imem requests.
RESET_PC, 'h0000, fetch PC after reset.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-low reset.
redirect_valid  in  1  branch/exception redirect from a later stage.
redirect_pc  in  XLEN  redirect target.
halt  in  1  while high, no new imem requests are issued.
imem_req_valid  out  1  request valid.
imem_req_ready  in  1  memory accepts the request.
imem_req_addr  out  XLEN  fetch address.
imem_rsp_valid  in  1  response valid. Responses are in order; no backpressure.
imem_rsp_data  in  ILEN  fetched instruction.
imem_rsp_err  in  1  bus error for this response.
inst_valid  out  1  head slot holds an instruction.
inst_ready  in  1  decode accepts it.
inst_ifid  out  ILEN  instruction to decode.
pc_ifid  out  XLEN  PC of inst_ifid.
err  out  1  sticky error flag.

Behaviour:
Reset (rst low, asynchronous):
- pc = RESET_PC; all slots empty; drop_cnt = 0; state = RUN.
- Outputs: imem_req_valid = 0, inst_valid = 0, err = 0, inst_ifid = 0, pc_ifid = 0.

Slot buffer:
- Circular, QDEPTH entries {pc, data, filled}, with alloc, fill and retire pointers.
- A request fire (imem_req_valid & imem_req_ready) allocates a slot tagged with pc, then pc += ILEN/8. PC wraps modulo 2^XLEN.

Issue:
- imem_req_valid = (state == RUN) & !halt & !redirect_valid & (allocated + drop_cnt < QDEPTH).
- imem_req_addr = pc.

Fill:
- A response with drop_cnt == 0 writes the fill-pointer slot and sets filled.
- That slot is visible on inst_valid the next cycle. Minimum request-to-decode latency is 2 cycles.

Retire:
- inst_valid = head.filled & !redirect_valid.
- On inst_valid & inst_ready, the head is freed. Alloc and retire may occur in the same cycle.
- Full condition holds allocation; empty holds inst_valid low.

Redirect (highest priority):
- Flush all slots.
- drop_cnt += number of slots allocated but not yet filled.
- pc = redirect_pc.
- If drop_cnt becomes nonzero, state = DRAIN.
- A response arriving in the redirect cycle counts as dropped.
- Any inst handshake in that cycle is void.

DRAIN:
- Each response decrements drop_cnt and is discarded.
- At 0, state returns to RUN.
- Requests are blocked in DRAIN.
- A further redirect in DRAIN adds to drop_cnt and replaces pc.

Errors:
- A redirect_pc that is not ILEN/8-aligned, or imem_rsp_err on a non-dropped response, sets err and state = ERR.
- In ERR: no new requests; older filled slots still drain to decode; the faulting slot is never presented; remaining responses are discarded.
- err clears only on reset.

Reset mid-operation: all state clears immediately. Memory responses to pre-reset requests are the memory's responsibility to squash.

Decomposition:
- Package fetch_pkg holds:
  - default XLEN/ILEN/RESET_PC constants;
  - typedef enum fetch_state_t {RUN, DRAIN, ERR};
  - a packed struct fetch_slot_t {pc, data, filled}.
- One sub-module, fetch_slot_buf: the circular slot buffer with alloc/fill/retire/flush ports and a count output.
- Issue control, PC and FSM stay in fetch_queue.

Test Plan:
1. Reset, memory always ready with 1-cycle response, inst_ready=1 -> requests at 0x0000, 0x0002, 0x0004…; pc_ifid follows that sequence, first inst_valid 2 cycles after the first request; err=0.
2. inst_ready=0, QDEPTH=4 -> exactly 4 request fires, then imem_req_valid=0; raising inst_ready drains the 4 in order and issue resumes.
3. 3 requests outstanding, then redirect_pc=0x0040 -> next 3 responses discarded; next decoded PC is 0x0040; no stale instruction reaches decode.
4. Redirect in the same cycle as inst_valid&inst_ready and a response -> handshake void, response dropped, drop_cnt correct.
5. imem_rsp_err on the 2nd response -> 1st instruction delivered, 2nd never presented, err=1 sticky, no further requests until rst low.
6. redirect_pc=0x0003 -> err=1, no request to 0x0003 issued.
